// File: rtl/wb_write_arbiter.sv
// Drives the register file's single write port, merging the in-order pipeline with a FIFO of
// multiply/divide results, and raises a decode interlock for registers whose write is still pending.
module wb_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic                     wb_regWrite,
    input  logic                     wb_memToReg,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_alu_result,
    input  logic [31:0]              wb_mem_data,
    output logic                     wb_stall,
    input  logic                     md_valid,
    output logic                     md_ready,
    input  logic [4:0]               md_rd,
    input  logic [31:0]              md_result,
    input  logic [4:0]               rs_1,
    input  logic [4:0]               rt_2,
    output logic                     pend_stall,
    output logic                     regWrite,
    output logic [4:0]               rd_w,
    output logic [31:0]              writeData,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifo_rd_q   [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [PTR_W-1:0] ptr_off     [DEPTH];
    logic [DEPTH-1:0] entry_valid;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       rd_w_q, rd_w_d;
    logic [31:0]      write_data_q, write_data_d;

    logic        preq, fifo_empty, push, pop, pipe_win;
    logic        rs_nz, rt_nz;
    logic [31:0] pipe_data;

    assign preq       = wb_valid & wb_regWrite & (wb_rd != 5'd0);
    assign pipe_data  = wb_memToReg ? wb_mem_data : wb_alu_result;
    assign fifo_empty = (count_q == '0);

    // Stall depends only on registered state so upstream never sees a combinational loop.
    assign wb_stall = !fifo_empty && (starve_q == STV_W'(STARVE_LIMIT));
    assign md_ready = (count_q < CNT_W'(DEPTH));
    assign push     = md_valid & md_ready & (md_rd != 5'd0);
    assign pop      = !fifo_empty & (wb_stall | !preq);
    assign pipe_win = preq & !wb_stall;

    always_comb begin
        // NOTE: every output gets a default first, so no path through this block can infer a latch.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_d     = starve_q;
        reg_write_d  = 1'b0;
        rd_w_d       = rd_w_q;
        write_data_d = write_data_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (pipe_win && (starve_q != STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end

        if (pop) begin
            reg_write_d  = 1'b1;
            rd_w_d       = fifo_rd_q[rd_ptr_q];
            write_data_d = fifo_data_q[rd_ptr_q];
        end else if (pipe_win) begin
            reg_write_d  = 1'b1;
            rd_w_d       = wb_rd;
            write_data_d = pipe_data;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        rs_nz = (rs_1 != 5'd0);
        rt_nz = (rt_2 != 5'd0);
        pend_stall = reg_write_q && ((rs_nz && (rd_w_q == rs_1)) || (rt_nz && (rd_w_q == rt_2)));
        for (int i = 0; i < DEPTH; i++) begin
            ptr_off[i]     = PTR_W'(i) - rd_ptr_q;
            entry_valid[i] = ({1'b0, ptr_off[i]} < count_q);
            if (entry_valid[i] &&
                ((rs_nz && (fifo_rd_q[i] == rs_1)) || (rt_nz && (fifo_rd_q[i] == rt_2)))) begin
                pend_stall = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            reg_write_q  <= 1'b0;
            rd_w_q       <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            reg_write_q  <= reg_write_d;
            rd_w_q       <= rd_w_d;
            write_data_q <= write_data_d;
        end
    end

    // NOTE: storage is not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= md_rd;
            fifo_data_q[wr_ptr_q] <= md_result;
        end
    end

    assign regWrite   = reg_write_q;
    assign rd_w       = rd_w_q;
    assign writeData  = write_data_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: per-cycle vectors plus a scoreboard of expected
// register-file writes, with hand-built sequences for starvation, pointer wrap and mid-run reset.
module tb_wb_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, wb_regWrite, wb_memToReg;
    logic [4:0]  wb_rd;
    logic [31:0] wb_alu_result, wb_mem_data;
    logic        wb_stall;
    logic        md_valid, md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic [4:0]  rs_1, rt_2;
    logic        pend_stall;
    logic        regWrite;
    logic [4:0]  rd_w;
    logic [31:0] writeData;
    logic [2:0]  fifo_count;

    wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg),
        .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .wb_stall(wb_stall),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_result(md_result),
        .rs_1(rs_1), .rt_2(rt_2), .pend_stall(pend_stall),
        .regWrite(regWrite), .rd_w(rd_w), .writeData(writeData), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv, wrw, wm;
        logic [4:0]  wrd;
        logic [31:0] alu, mem;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic [4:0]  rs, rt;
        logic        e_rw, e_stall, e_ready, e_pend;
        logic [2:0]  e_cnt;
        logic        sb;
        logic [4:0]  sb_rd;
        logic [31:0] sb_data;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t  sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write seen on the port must match the oldest outstanding expected write.
    task automatic sb_check(input string tag);
        wr_t e;
        if (regWrite === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.unexpected_write: got rd %0d data 0x%0h, expected no write",
                         tag, rd_w, writeData);
            end else begin
                e = sb_q.pop_front();
                check({tag, ".rd_w"}, 32'(rd_w), 32'(e.rd));
                check({tag, ".writeData"}, writeData, e.data);
            end
        end
    endtask

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
              1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input string tag);
        wb_valid      = v.wv;
        wb_regWrite   = v.wrw;
        wb_memToReg   = v.wm;
        wb_rd         = v.wrd;
        wb_alu_result = v.alu;
        wb_mem_data   = v.mem;
        md_valid      = v.mv;
        md_rd         = v.mrd;
        md_result     = v.mres;
        rs_1          = v.rs;
        rt_2          = v.rt;
        if (v.sb) sb_q.push_back('{rd: v.sb_rd, data: v.sb_data});
        @(negedge clk);
        sb_check(tag);
        check({tag, ".regWrite"},   32'(regWrite),   32'(v.e_rw));
        check({tag, ".wb_stall"},   32'(wb_stall),   32'(v.e_stall));
        check({tag, ".md_ready"},   32'(md_ready),   32'(v.e_ready));
        check({tag, ".pend_stall"}, 32'(pend_stall), 32'(v.e_pend));
        check({tag, ".fifo_count"}, 32'(fifo_count), 32'(v.e_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".regWrite"},   32'(regWrite),   32'h0);
        check({tag, ".rd_w"},       32'(rd_w),       32'h0);
        check({tag, ".writeData"},  writeData,       32'h0);
        check({tag, ".fifo_count"}, 32'(fifo_count), 32'h0);
        check({tag, ".md_ready"},   32'(md_ready),   32'h1);
        check({tag, ".wb_stall"},   32'(wb_stall),   32'h0);
        check({tag, ".pend_stall"}, 32'(pend_stall), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   cnt_fill[11];
        int   cnt_wrap[14];

        //          wv    wrw   wm    wrd    alu           mem            mv    mrd    mres          rs     rt     rw    stall rdy   pend  cnt   sb    sb_rd  sb_data
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 5'd5, 32'h1234,     32'hFFFF0000,  1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 5'd5, 32'h1234};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 5'd6, 32'h1111,     32'hDEADBEEF,  1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 5'd6, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h5555,     32'h0,         1'b0, 5'd0, 32'h0,        5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 5'd7, 32'h7777,     32'h0,         1'b0, 5'd0, 32'h0,        5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'd8, 32'h8888,     32'h0,         1'b0, 5'd0, 32'h0,        5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 5'd9, 32'hA5A5A5A5};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 5'd0, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0, 5'd0, 32'h0,        5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b1, 5'd0, 32'h77,       5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 32'h0};

        cnt_fill = '{0, 1, 2, 3, 4, 3, 3, 2, 1, 0, 0};
        cnt_wrap = '{0, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 0, 0};

        // Reset and idle.
        v = idle_vec();
        rst = 1'b1;
        wb_valid = 1'b0; wb_regWrite = 1'b0; wb_memToReg = 1'b0; wb_rd = 5'd0;
        wb_alu_result = 32'h0; wb_mem_data = 32'h0;
        md_valid = 1'b0; md_rd = 5'd0; md_result = 32'h0; rs_1 = 5'd0; rt_2 = 5'd0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pipeline writes, $0 suppression, single md result, md_rd==0 drop.
        for (int i = 0; i < 13; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
        check("hold.rd_w", 32'(rd_w), 32'd9);
        check("hold.writeData", writeData, 32'hA5A5A5A5);

        // Fill the FIFO while the pipeline writes every cycle; starvation forces a stall.
        for (int k = 0; k <= 10; k++) begin
            v = idle_vec();
            if (k <= 5) begin
                v.wv = 1'b1; v.wrw = 1'b1;
                v.wrd = (k <= 3) ? 5'(10 + k) : 5'd14;
                v.alu = (k <= 3) ? 32'(32'h100 + k) : 32'h104;
            end
            if (k <= 4) begin
                v.mv = 1'b1; v.mrd = 5'(20 + k); v.mres = 32'(32'h200 + k);
            end
            if (k == 4) begin
                v.rt = 5'd23; v.e_pend = 1'b1;
            end
            v.e_cnt   = 3'(cnt_fill[k]);
            v.e_ready = (cnt_fill[k] < 4);
            v.e_stall = (k == 4);
            v.e_rw    = (k >= 1 && k <= 9);
            v.sb      = (k <= 8);
            if (k <= 3)      begin v.sb_rd = 5'(10 + k); v.sb_data = 32'(32'h100 + k); end
            else if (k == 4) begin v.sb_rd = 5'd20;      v.sb_data = 32'h200;          end
            else if (k == 5) begin v.sb_rd = 5'd14;      v.sb_data = 32'h104;          end
            else             begin v.sb_rd = 5'(15 + k); v.sb_data = 32'(32'h1FB + k); end
            apply_vec(v, $sformatf("fill%0d", k));
        end

        // Steady push+pop at count 2 across several pointer wraps.
        for (int k = 0; k <= 13; k++) begin
            v = idle_vec();
            if (k <= 1) begin
                v.wv = 1'b1; v.wrw = 1'b1; v.wrd = 5'(30 + k); v.alu = 32'(32'h300 + k);
            end
            if (k <= 9) begin
                v.mv = 1'b1; v.mrd = 5'(11 + k); v.mres = 32'(32'hC0000000 + k);
            end
            if (k >= 2 && k <= 10) begin
                v.rs = 5'(10 + k); v.e_pend = 1'b1;
            end
            v.e_cnt = 3'(cnt_wrap[k]);
            v.e_rw  = (k >= 1 && k <= 12);
            v.sb    = (k <= 11);
            if (k <= 1) begin v.sb_rd = 5'(30 + k); v.sb_data = 32'(32'h300 + k);        end
            else        begin v.sb_rd = 5'(9 + k);  v.sb_data = 32'(32'hC0000000 + k - 2); end
            apply_vec(v, $sformatf("wrap%0d", k));
        end

        // Asynchronous reset with three entries queued.
        for (int k = 0; k <= 2; k++) begin
            v = idle_vec();
            v.wv = 1'b1; v.wrw = 1'b1; v.wrd = 5'(40 + k); v.alu = 32'(32'h400 + k);
            v.mv = 1'b1; v.mrd = 5'(25 + k); v.mres = 32'(32'h500 + k);
            v.e_cnt = 3'(k);
            v.e_rw  = (k >= 1);
            v.sb = 1'b1; v.sb_rd = 5'(40 + k); v.sb_data = 32'(32'h400 + k);
            apply_vec(v, $sformatf("prerst%0d", k));
        end
        wb_valid = 1'b0; wb_regWrite = 1'b0; md_valid = 1'b0; rs_1 = 5'd42; rt_2 = 5'd25;
        check("prerst.fifo_count", 32'(fifo_count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) apply_vec(idle_vec(), $sformatf("postrst%0d", k));

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Writeback-side driver of the register file's single write port (regWrite, rd_w, writeData). Merges two result producers: the in-order pipeline (MEM/WB: ALU result or load data) and an out-of-band multi-cycle multiply/divide unit. Multiply/divide results queue in a small FIFO, and the block arbitrates them onto the one write port. It also generates a decode-stage interlock for registers whose write is still pending.

Parameters:
DEPTH, 4, multiply/divide result FIFO entries (power of two, 2..16)
STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose to the pipeline before the pipeline is stalled

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
wb_valid  input  1  pipeline instruction present in WB
wb_regWrite  input  1  pipeline instruction writes a register
wb_memToReg  input  1  1 = write wb_mem_data, 0 = write wb_alu_result
wb_rd  input  5  pipeline destination register
wb_alu_result  input  32  ALU result
wb_mem_data  input  32  load data
wb_stall  output  1  pipeline must hold WB inputs this cycle
md_valid  input  1  multiply/divide result offered
md_ready  output  1  FIFO can accept
md_rd  input  5  multiply/divide destination register
md_result  input  32  multiply/divide result
rs_1  input  5  decode read address 1
rt_2  input  5  decode read address 2
pend_stall  output  1  rs_1 or rt_2 has a pending write
regWrite  output  1  register file write enable (registered)
rd_w  output  5  register file write address (registered)
writeData  output  32  register file write data (registered)
fifo_count  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, any time, including mid-operation): regWrite=0, rd_w=0, writeData=0, FIFO emptied (contents discarded), fifo_count=0, starve counter=0. wb_stall=0, md_ready=1, pend_stall=0 after reset.
- Pipeline request: preq = wb_valid & wb_regWrite & (wb_rd!=0). Writes to $0 never reach the port.
- Pipeline data select: wb_memToReg ? wb_mem_data : wb_alu_result.
- Arbitration, evaluated each cycle:
  - wb_stall = (fifo_count!=0) & (starve==STARVE_LIMIT). Combinational, from registered state only.
  - If wb_stall: FIFO head wins and pipeline inputs are ignored. Upstream holds them and re-presents them next cycle.
  - Else if preq: pipeline wins.
  - Else if FIFO non-empty: FIFO head wins (pop).
  - Else: no write.
- Output register at the edge: regWrite<=winner exists, rd_w/writeData<=winner's rd/data. With no winner, regWrite<=0 and rd_w/writeData hold their previous values.
- Latency: pipeline result appears on the write port 1 cycle after it is sampled. An md result accepted at edge N is poppable in cycle N+1 and appears on the port after edge N+1 at the earliest. There is no bypass around the FIFO.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when FIFO non-empty and pipeline wins.
  - Clears on any pop.
  - Clears when FIFO empty.
- FIFO:
  - md_ready = (fifo_count < DEPTH). Depends on count only, so no push at full even if a pop occurs the same cycle.
  - Push when md_valid & md_ready & (md_rd!=0). md_valid & md_ready with md_rd==0 is accepted and dropped.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH. Strict FIFO order, so two pending writes to the same rd retire oldest first.
- pend_stall (combinational) is asserted when either nonzero rs_1 or nonzero rt_2 equals:
  - the rd of any valid FIFO entry, or
  - rd_w while regWrite=1, since that write is not yet in the register file this cycle.
  - Address 0 never matches.
- WAW ordering between a pipeline write and an md write to the same rd is upstream's responsibility. Decode uses pend_stall; this block does not reorder.

Test Plan:
- Reset then idle → regWrite=0, rd_w=0, writeData=0, md_ready=1, fifo_count=0, pend_stall=0. Assert rst mid-run with FIFO holding 3 entries → count 0 and regWrite 0 immediately.
- Pipeline write: wb_valid=1, wb_regWrite=1, wb_rd=5, wb_memToReg=0, alu=0x1234 → next cycle regWrite=1, rd_w=5, writeData=0x1234. Repeat with memToReg=1, mem=0xDEADBEEF → writeData=0xDEADBEEF. Repeat with wb_rd=0 → regWrite stays 0.
- MD path with pipeline idle: push rd=9, data=0xA5A5A5A5 → fifo_count=1; one cycle later regWrite=1, rd_w=9. pend_stall=1 for rs_1=9 from the push edge through the write cycle.
- Fill FIFO: 4 pushes while the pipeline writes every cycle → md_ready=0 at count 4. wb_stall=1 in exactly the 4th cycle (STARVE_LIMIT=3 losses); head rd retires. Pipeline write retires the cycle after wb_stall drops.
- Push and pop same cycle at count 2 → count stays 2, retire order matches push order. Pointer wrap exercised over 10 pushes with correct rd/data sequence.
- md_rd=0 with md_valid=1 → accepted, fifo_count unchanged, no write issued.
